// File: rtl/vga_rect_compositor.sv
// VGA timing generator with frame-cadence LFSR placement of NUM_RECT rectangles
// and a fixed-priority compositor. All pins are driven from registers.
module vga_rect_compositor #(
  parameter int unsigned H_VISIBLE         = 640,
  parameter int unsigned H_FP              = 16,
  parameter int unsigned H_SYNC            = 96,
  parameter int unsigned H_BP              = 48,
  parameter int unsigned V_VISIBLE         = 480,
  parameter int unsigned V_FP              = 10,
  parameter int unsigned V_SYNC            = 2,
  parameter int unsigned V_BP              = 33,
  parameter bit          HSYNC_POL         = 1'b0,
  parameter bit          VSYNC_POL         = 1'b0,
  parameter int unsigned NUM_RECT          = 2,
  parameter int unsigned COLOR_W           = 2,
  parameter int unsigned FRAMES_PER_UPDATE = 60,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               upd
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned CW      = (HW > VW) ? HW : VW;
  // Raw sample widths: 10/9 bits at 640x480, always < 2x the visible range.
  localparam int unsigned X_BITS  = $clog2(H_VISIBLE);
  localparam int unsigned Y_BITS  = $clog2(V_VISIBLE);
  localparam int unsigned FW      = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;
  localparam int unsigned GEN_LEN = 4 * NUM_RECT;
  localparam int unsigned GW      = $clog2(GEN_LEN);

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  state_e              state_q, state_d;
  logic [GW-1:0]       gen_cnt_q, gen_cnt_d;
  logic                tick, place, commit;
  logic [CW-1:0]       x_smp, y_smp, sample;
  logic [CW-1:0]       shadow_q [GEN_LEN];
  logic [CW-1:0]       shadow_d [GEN_LEN];
  logic [CW-1:0]       left_q [NUM_RECT];
  logic [CW-1:0]       right_q [NUM_RECT];
  logic [CW-1:0]       top_q [NUM_RECT];
  logic [CW-1:0]       bottom_q [NUM_RECT];
  logic [NUM_RECT-1:0] valid_q, hit;
  logic [CW-1:0]       hx, vy;
  logic                visible, hs_on, vs_on;
  logic [COLOR_W-1:0]  red_d, green_d, blue_d;

  function automatic logic [CW-1:0] cmin(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] cmax(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Raster counters: h wraps every line, v advances on h wrap.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  assign tick = (h_q == '0) && (v_q == VW'(V_VISIBLE));

  // Frame cadence: placement event every FRAMES_PER_UPDATE ticks unless frozen.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    place       = 1'b0;
    if (tick) begin
      if (frame_cnt_q == FW'(FRAMES_PER_UPDATE - 1)) begin
        frame_cnt_d = '0;
        place       = ~freeze;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Galois LFSR, x^16+x^14+x^13+x^11+1, free running.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Fold raw LFSR bits into the visible range and pick x or y by sample slot.
  always_comb begin
    x_smp = CW'(lfsr_q[X_BITS-1:0]);
    if (x_smp >= CW'(H_VISIBLE)) x_smp = x_smp - CW'(H_VISIBLE);
    y_smp = CW'(lfsr_q[Y_BITS-1:0]);
    if (y_smp >= CW'(V_VISIBLE)) y_smp = y_smp - CW'(V_VISIBLE);
    sample = gen_cnt_q[1] ? y_smp : x_smp;
  end

  // Placement FSM: one coordinate per GEN cycle, commit on the last one.
  always_comb begin
    state_d   = state_q;
    gen_cnt_d = gen_cnt_q;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (place) begin
          state_d   = StGen;
          gen_cnt_d = '0;
        end
      end
      StGen: begin
        if (gen_cnt_q == GW'(GEN_LEN - 1)) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else begin
          gen_cnt_d = gen_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Shadow bank write; the commit reads this so the final sample is included.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == StGen) shadow_d[gen_cnt_q] = sample;
  end

  // Timing, cadence, LFSR, FSM and shadow state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      state_q     <= StIdle;
      gen_cnt_q   <= '0;
      for (int i = 0; i < GEN_LEN; i++) shadow_q[i] <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
      state_q     <= state_d;
      gen_cnt_q   <= gen_cnt_d;
      shadow_q    <= shadow_d;
    end
  end

  // Active rectangle set, replaced atomically on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        left_q[i]   <= '0;
        right_q[i]  <= '0;
        top_q[i]    <= '0;
        bottom_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        left_q[i]   <= cmin(shadow_d[4*i],     shadow_d[4*i + 1]);
        right_q[i]  <= cmax(shadow_d[4*i],     shadow_d[4*i + 1]);
        top_q[i]    <= cmin(shadow_d[4*i + 2], shadow_d[4*i + 3]);
        bottom_q[i] <= cmax(shadow_d[4*i + 2], shadow_d[4*i + 3]);
      end
      valid_q <= '1;
    end
  end

  assign hx      = CW'(h_q);
  assign vy      = CW'(v_q);
  assign visible = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
  assign hs_on   = (h_q >= HW'(H_VISIBLE + H_FP)) && (h_q <= HW'(H_VISIBLE + H_FP + H_SYNC - 1));
  assign vs_on   = (v_q >= VW'(V_VISIBLE + V_FP)) && (v_q <= VW'(V_VISIBLE + V_FP + V_SYNC - 1));

  // Inclusive-bound hit test per channel.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RECT; i++) begin
      hit[i] = valid_q[i] && (hx >= left_q[i]) && (hx <= right_q[i]) &&
               (vy >= top_q[i]) && (vy <= bottom_q[i]);
    end
  end

  // Compositor: walk from highest channel down so the lowest hitting one wins.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (visible) begin
      red_d   = '1;
      green_d = '1;
      blue_d  = '1;
      for (int i = int'(NUM_RECT) - 1; i >= 0; i--) begin
        if (hit[i]) begin
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
          case (i % 4)
            0:       red_d = '1;
            1:       blue_d = '1;
            2:       green_d = '1;
            default: begin
              red_d   = '1;
              green_d = '1;
            end
          endcase
        end
      end
    end
  end

  // Output register stage keeps sync and colour aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      red   <= '0;
      green <= '0;
      blue  <= '0;
      upd   <= 1'b0;
    end else begin
      hsync <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      red   <= red_d;
      green <= green_d;
      blue  <= blue_d;
      upd   <= commit;
    end
  end

endmodule

// File: tb/tb_vga_rect_compositor.sv
// Bench: a small-raster DUT checked against hand vectors and a cycle model,
// plus a default-parameter DUT checked for line timing.
module tb_vga_rect_compositor;

  localparam int HV = 20, HF = 2, HS = 3, HB = 3, HT = 28;
  localparam int VV = 12, VF = 1, VS = 2, VB = 2, VT = 17;
  localparam int NR = 2, FPU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       freeze = 1'b0;
  logic       hs, vs, upd, d_hs, d_vs, d_upd;
  logic [1:0] r, g, b, d_r, d_g, d_b;

  always #5 clk = ~clk;

  vga_rect_compositor #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .NUM_RECT(NR), .COLOR_W(2),
    .FRAMES_PER_UPDATE(FPU), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .hsync(hs), .vsync(vs),
    .red(r), .green(g), .blue(b), .upd(upd)
  );

  vga_rect_compositor u_def (
    .clk(clk), .rst(rst), .freeze(freeze), .hsync(d_hs), .vsync(d_vs),
    .red(d_r), .green(d_g), .blue(d_b), .upd(d_upd)
  );

  typedef struct {
    int         c;
    bit         dflt;
    logic [8:0] exp;
  } vec_t;

  vec_t tab[$];
  int   ti = 0;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, n_upd = 0, n_white = 0;

  // Reference model state: raster position, cadence, LFSR, placement.
  int          mh, mv, mfc, mgen;
  logic [15:0] ml;
  int          sh[4*NR];
  int          lft[NR], rgt[NR], tp[NR], bt[NR];
  bit          mval[NR];
  logic [8:0]  e_out;
  bit          e_vis;

  function automatic logic [8:0] small_out();
    return {hs, vs, r, g, b, upd};
  endfunction

  function automatic logic [8:0] def_out();
    return {d_hs, d_vs, d_r, d_g, d_b, d_upd};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input bit dflt, input logic h, input logic v,
                     input logic [1:0] rr, input logic [1:0] gg, input logic [1:0] bb,
                     input logic u);
    vec_t t;
    t.c    = c;
    t.dflt = dflt;
    t.exp  = {h, v, rr, gg, bb, u};
    tab.push_back(t);
  endtask

  task automatic model_reset();
    mh   = 0;
    mv   = 0;
    mfc  = 0;
    mgen = -1;
    ml   = 16'hACE1;
    for (int i = 0; i < NR; i++) mval[i] = 1'b0;
  endtask

  // Expected outputs come from the pre-edge state; then the state advances.
  task automatic model_step();
    bit tk, found;
    int s;
    e_vis    = (mh < HV) && (mv < VV);
    e_out[8] = !((mh >= HV + HF) && (mh < HV + HF + HS));
    e_out[7] = !((mv >= VV + VF) && (mv < VV + VF + VS));
    e_out[0] = (mgen == 4*NR - 1);
    e_out[6:1] = 6'b0;
    if (e_vis) begin
      e_out[6:1] = 6'b111111;
      found = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!found && mval[i] && mh >= lft[i] && mh <= rgt[i] && mv >= tp[i] && mv <= bt[i]) begin
          found = 1'b1;
          e_out[6:1] = (i == 0) ? 6'b110000 : 6'b000011;
        end
      end
    end
    tk = (mh == 0) && (mv == VV);
    if (mgen >= 0) begin
      if ((mgen % 4) < 2) begin
        s = int'(ml[4:0]);
        if (s >= HV) s = s - HV;
      end else begin
        s = int'(ml[3:0]);
        if (s >= VV) s = s - VV;
      end
      sh[mgen] = s;
      if (mgen == 4*NR - 1) begin
        for (int i = 0; i < NR; i++) begin
          lft[i]  = (sh[4*i] < sh[4*i+1]) ? sh[4*i] : sh[4*i+1];
          rgt[i]  = (sh[4*i] < sh[4*i+1]) ? sh[4*i+1] : sh[4*i];
          tp[i]   = (sh[4*i+2] < sh[4*i+3]) ? sh[4*i+2] : sh[4*i+3];
          bt[i]   = (sh[4*i+2] < sh[4*i+3]) ? sh[4*i+3] : sh[4*i+2];
          mval[i] = 1'b1;
        end
        mgen = -1;
      end else begin
        mgen++;
      end
    end else if (tk && mfc == FPU - 1 && !freeze) begin
      mgen = 0;
    end
    if (tk) mfc = (mfc == FPU - 1) ? 0 : mfc + 1;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    ml = lfsr_next(ml);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    cmp("pixel_model", 16'(small_out()), 16'(e_out));
    if (upd === 1'b1) n_upd++;
    if (e_vis && {r, g, b} === 6'b111111) n_white++;
    while (ti < tab.size() && tab[ti].c == cyc) begin
      if (tab[ti].dflt) cmp($sformatf("vec%0d_def", ti), 16'(def_out()), 16'(tab[ti].exp));
      else              cmp($sformatf("vec%0d_small", ti), 16'(small_out()), 16'(tab[ti].exp));
      ti++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    bit found;
    // Hand vectors: output at cycle c shows counter state c-1.
    add(1,    0, 1, 1, 3, 3, 3, 0);
    add(1,    1, 1, 1, 3, 3, 3, 0);
    add(20,   0, 1, 1, 3, 3, 3, 0);
    add(21,   0, 1, 1, 0, 0, 0, 0);
    add(22,   0, 1, 1, 0, 0, 0, 0);
    add(23,   0, 0, 1, 0, 0, 0, 0);
    add(25,   0, 0, 1, 0, 0, 0, 0);
    add(26,   0, 1, 1, 0, 0, 0, 0);
    add(29,   0, 1, 1, 3, 3, 3, 0);
    add(316,  0, 1, 1, 3, 3, 3, 0);
    add(336,  0, 1, 1, 0, 0, 0, 0);
    add(337,  0, 1, 1, 0, 0, 0, 0);
    add(364,  0, 1, 1, 0, 0, 0, 0);
    add(365,  0, 1, 0, 0, 0, 0, 0);
    add(388,  0, 0, 0, 0, 0, 0, 0);
    add(420,  0, 1, 0, 0, 0, 0, 0);
    add(421,  0, 1, 1, 0, 0, 0, 0);
    add(477,  0, 1, 1, 3, 3, 3, 0);
    add(640,  1, 1, 1, 3, 3, 3, 0);
    add(641,  1, 1, 1, 0, 0, 0, 0);
    add(656,  1, 1, 1, 0, 0, 0, 0);
    add(657,  1, 0, 1, 0, 0, 0, 0);
    add(752,  1, 0, 1, 0, 0, 0, 0);
    add(753,  1, 1, 1, 0, 0, 0, 0);
    add(801,  1, 1, 1, 3, 3, 3, 0);
    add(813,  0, 1, 1, 0, 0, 0, 0);
    add(820,  0, 1, 1, 0, 0, 0, 0);
    add(821,  0, 1, 1, 0, 0, 0, 1);
    add(822,  0, 1, 1, 0, 0, 0, 0);
    add(1456, 1, 1, 1, 0, 0, 0, 0);
    add(1457, 1, 0, 1, 0, 0, 0, 0);
    add(1773, 0, 1, 1, 0, 0, 0, 1);
    add(1774, 0, 1, 1, 0, 0, 0, 0);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_small", 16'(small_out()), 16'h180);
    cmp("reset_default", 16'(def_out()), 16'h180);
    rst = 1'b1;
    cyc = 0;

    // Background, sync timing and first two placements.
    run(1800);
    cmp("upd_count_first", 16'(n_upd), 16'd2);

    // Freeze held across the event tick at cycle 2716.
    run(700);
    freeze = 1'b1;
    n_upd  = 0;
    run(400);
    freeze = 1'b0;
    cmp("freeze_no_upd", 16'(n_upd), 16'd0);

    // Long run: many random placements, priority and bounds via the model.
    n_upd = 0;
    run(17000);
    cmp("upd_count_long", 16'(n_upd), 16'd18);

    // Reset in the middle of GEN.
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      step();
      if (mgen == 3) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gen_wait at cycle %0d: got no GEN window, expected one", cyc);
    end
    #2;
    rst = 1'b0;
    #1;
    cmp("async_reset_small", 16'(small_out()), 16'h180);
    cmp("async_reset_default", 16'(def_out()), 16'h180);
    @(posedge clk);
    #1;
    cmp("reset_hold", 16'(small_out()), 16'h180);
    rst = 1'b1;
    cyc = 0;
    model_reset();
    n_upd   = 0;
    n_white = 0;
    run(500);
    cmp("post_reset_no_upd", 16'(n_upd), 16'd0);
    cmp("post_reset_white", 16'(n_white), 16'd260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
